// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad code lock.
package keypad_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StEntry,
    StCheck,
    StLockout
  } state_e;

  localparam logic [3:0] KEY_SUBMIT = 4'hF;

endpackage

// File: rtl/keypad_code_lock_if.sv
// Key input, code table and status outputs of the keypad code lock.
interface keypad_code_lock_if #(
  parameter int unsigned CODE_LEN  = 4,
  parameter int unsigned NUM_CODES = 3
) ();

  logic                                key_valid;
  logic [3:0]                          key_value;
  logic [NUM_CODES*CODE_LEN*4-1:0]     code_table;
  logic                                match;
  logic [$clog2(NUM_CODES)-1:0]        match_idx;
  logic                                fail;
  logic                                armed;
  logic                                locked_out;
  logic [$clog2(CODE_LEN+1)-1:0]       digit_count;

  modport master (
    output key_valid, key_value, code_table,
    input  match, match_idx, fail, armed, locked_out, digit_count
  );

  modport slave (
    input  key_valid, key_value, code_table,
    output match, match_idx, fail, armed, locked_out, digit_count
  );

endinterface

// File: rtl/cycle_timer.sv
// Load/countdown/expire counter: expired_o is high in the CYCLES-th cycle after a load.
module cycle_timer #(
  parameter int unsigned CYCLES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(CYCLES);

  logic [CntW-1:0] count_q;
  logic            running_q;

  assign expired_o = running_q && (count_q == '0);

  // A load wins over both a clear and an expiry in the same cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q   <= '0;
      running_q <= 1'b0;
    end else if (load_i) begin
      count_q   <= CntW'(CYCLES - 1);
      running_q <= 1'b1;
    end else if (clear_i || expired_o) begin
      count_q   <= '0;
      running_q <= 1'b0;
    end else if (running_q) begin
      count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/keypad_code_lock.sv
// Keypad code lock: buffers the last CODE_LEN digits, checks them against a code table on
// submit, toggles armed on codes 0/1 and locks out after repeated failures.
module keypad_code_lock
  import keypad_pkg::*;
#(
  parameter int unsigned CODE_LEN       = 4,
  parameter int unsigned NUM_CODES      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 24_000_000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 48_000_000
) (
  input logic               clk,
  input logic               reset,
  keypad_code_lock_if.slave bus_io
);

  localparam int unsigned IdxW  = $clog2(NUM_CODES);
  localparam int unsigned CntW  = $clog2(CODE_LEN + 1);
  localparam int unsigned FailW = $clog2(MAX_FAILS + 1);

  state_e          state_q;
  logic [3:0]      buf_q [CODE_LEN];
  logic [CntW-1:0] cnt_q;
  logic [FailW-1:0] fails_q;
  logic            match_q;
  logic            fail_q;
  logic            armed_q;
  logic            locked_q;
  logic [IdxW-1:0] idx_q;

  logic            open_win;
  logic            key_acc;
  logic            submit;
  logic            code_eq;
  logic            hit;
  logic [IdxW-1:0] hit_idx;
  logic            lock_start;
  logic            to_expired;
  logic            lk_expired;

  always_comb begin
    open_win   = (state_q == StIdle) || (state_q == StEntry);
    key_acc    = open_win && bus_io.key_valid && (bus_io.key_value != KEY_SUBMIT);
    submit     = open_win && bus_io.key_valid && (bus_io.key_value == KEY_SUBMIT);
    code_eq    = 1'b0;
    hit        = 1'b0;
    hit_idx    = '0;
    // Scan from the top so the lowest matching index is the one left standing.
    for (int i = int'(NUM_CODES) - 1; i >= 0; i--) begin
      code_eq = (cnt_q == CntW'(CODE_LEN));
      for (int j = 0; j < int'(CODE_LEN); j++) begin
        if (buf_q[j] != bus_io.code_table[(i*int'(CODE_LEN)+j)*4 +: 4]) code_eq = 1'b0;
      end
      if (code_eq) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
      end
    end
    lock_start = (state_q == StCheck) && !hit && ((32'(fails_q) + 32'd1) >= MAX_FAILS);
  end

  cycle_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk),
    .reset_i   (reset),
    .load_i    (key_acc),
    .clear_i   (submit),
    .expired_o (to_expired)
  );

  cycle_timer #(
    .CYCLES (LOCKOUT_CYCLES)
  ) u_lockout (
    .clk_i     (clk),
    .reset_i   (reset),
    .load_i    (lock_start),
    .clear_i   (1'b0),
    .expired_o (lk_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      for (int j = 0; j < int'(CODE_LEN); j++) buf_q[j] <= '0;
      cnt_q    <= '0;
      fails_q  <= '0;
      match_q  <= 1'b0;
      fail_q   <= 1'b0;
      armed_q  <= 1'b0;
      locked_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      match_q <= 1'b0;
      fail_q  <= 1'b0;
      unique case (state_q)
        StIdle, StEntry: begin
          if (key_acc) begin
            // Newest digit enters at the top; index 0 holds the oldest retained digit.
            for (int j = 0; j < int'(CODE_LEN) - 1; j++) buf_q[j] <= buf_q[j+1];
            buf_q[CODE_LEN-1] <= bus_io.key_value;
            if (cnt_q != CntW'(CODE_LEN)) cnt_q <= cnt_q + 1'b1;
            state_q <= StEntry;
          end else if (submit) begin
            state_q <= StCheck;
          end else if ((state_q == StEntry) && to_expired) begin
            for (int j = 0; j < int'(CODE_LEN); j++) buf_q[j] <= '0;
            cnt_q   <= '0;
            state_q <= StIdle;
          end
        end
        StCheck: begin
          for (int j = 0; j < int'(CODE_LEN); j++) buf_q[j] <= '0;
          cnt_q <= '0;
          if (hit) begin
            match_q <= 1'b1;
            idx_q   <= hit_idx;
            fails_q <= '0;
            if (hit_idx == IdxW'(0)) armed_q <= 1'b1;
            else if (hit_idx == IdxW'(1)) armed_q <= 1'b0;
            state_q <= StIdle;
          end else begin
            fail_q  <= 1'b1;
            fails_q <= fails_q + 1'b1;
            if (lock_start) begin
              locked_q <= 1'b1;
              state_q  <= StLockout;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StLockout: begin
          if (lk_expired) begin
            locked_q <= 1'b0;
            fails_q  <= '0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.match       = match_q;
  assign bus_io.match_idx   = idx_q;
  assign bus_io.fail        = fail_q;
  assign bus_io.armed       = armed_q;
  assign bus_io.locked_out  = locked_q;
  assign bus_io.digit_count = cnt_q;

endmodule

// File: tb/tb_keypad_code_lock.sv
// Directed bench for keypad_code_lock with a short timeout/lockout configuration.
module tb_keypad_code_lock;
  import keypad_pkg::*;

  localparam int unsigned CL = 4;
  localparam int unsigned NC = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  keypad_code_lock_if #(.CODE_LEN(CL), .NUM_CODES(NC)) bus ();

  keypad_code_lock #(
    .CODE_LEN       (CL),
    .NUM_CODES      (NC),
    .TIMEOUT_CYCLES (20),
    .MAX_FAILS      (3),
    .LOCKOUT_CYCLES (30)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus.slave)
  );

  int tests = 0;
  int errs  = 0;
  logic [3:0] lk_keys [5] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the key is sampled on the next posedge.
  task automatic press(input logic [3:0] k);
    bus.key_valid = 1'b1;
    bus.key_value = k;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic enter4(input logic [15:0] d);
    for (int i = 0; i < 4; i++) press(d[i*4 +: 4]);
  endtask

  task automatic submit_check(input string tag, input bit exp_match, input int exp_idx);
    press(KEY_SUBMIT);
    chk($sformatf("%s_check_quiet", tag), {bus.match, bus.fail}, 0);
    @(negedge clk);
    chk($sformatf("%s_match", tag), bus.match, exp_match);
    chk($sformatf("%s_fail", tag), bus.fail, !exp_match);
    if (exp_match) chk($sformatf("%s_idx", tag), bus.match_idx, exp_idx);
    chk($sformatf("%s_dcnt", tag), bus.digit_count, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk($sformatf("%s_match", tag), bus.match, 0);
    chk($sformatf("%s_fail", tag), bus.fail, 0);
    chk($sformatf("%s_idx", tag), bus.match_idx, 0);
    chk($sformatf("%s_armed", tag), bus.armed, 0);
    chk($sformatf("%s_locked", tag), bus.locked_out, 0);
    chk($sformatf("%s_dcnt", tag), bus.digit_count, 0);
  endtask

  initial begin
    int  lk_cycles;
    bit  spur;
    bus.key_valid  = 1'b0;
    bus.key_value  = 4'h0;
    bus.code_table = {16'h6425, 16'hBA98, 16'h3210};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Basic arm with code 0.
    enter4(16'h3210);
    chk("r41_dcnt4", bus.digit_count, 4);
    submit_check("r41", 1'b1, 0);
    chk("r41_armed", bus.armed, 1);
    @(negedge clk);
    chk("r41_pulse_end", bus.match, 0);

    // Oldest digit discarded, then disarm with code 1.
    press(4'h7);
    enter4(16'h3210);
    chk("r42_dcnt_sat", bus.digit_count, 4);
    submit_check("r42a", 1'b1, 0);
    enter4(16'hBA98);
    submit_check("r42b", 1'b1, 1);
    chk("r42_disarmed", bus.armed, 0);

    // Code 2 leaves armed alone.
    enter4(16'h3210);
    submit_check("r43_arm", 1'b1, 0);
    enter4(16'h6425);
    submit_check("r43", 1'b1, 2);
    chk("r43_armed_kept", bus.armed, 1);

    // Three failures then lockout.
    for (int k = 0; k < 3; k++) begin
      press(4'h1);
      press(4'h1);
      submit_check($sformatf("r44_f%0d", k), 1'b0, 0);
      chk($sformatf("r44_locked%0d", k), bus.locked_out, (k == 2) ? 1 : 0);
    end
    lk_cycles = 0;
    spur = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      if (bus.locked_out) lk_cycles++;
      if (bus.match || (n > 1 && bus.fail)) spur = 1'b1;
      if (n >= 2 && n <= 6) begin
        bus.key_valid = 1'b1;
        bus.key_value = lk_keys[n-2];
      end else begin
        bus.key_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("r44_lock_len", lk_cycles, 30);
    chk("r44_no_spurious", spur, 0);
    chk("r44_unlocked", bus.locked_out, 0);
    chk("r44_keys_ignored", bus.digit_count, 0);
    chk("r44_armed_kept", bus.armed, 1);
    enter4(16'h3210);
    submit_check("r44_after", 1'b1, 0);

    // Timeout abandons a partial entry.
    press(4'h0);
    press(4'h1);
    repeat (19) @(negedge clk);
    chk("r45_before_expiry", bus.digit_count, 2);
    @(negedge clk);
    chk("r45_expired", bus.digit_count, 0);
    press(4'h2);
    press(4'h3);
    submit_check("r45_short", 1'b0, 0);

    // Key on the expiry cycle wins.
    press(4'h0);
    press(4'h1);
    repeat (19) @(negedge clk);
    press(4'h2);
    chk("r45_key_on_expiry", bus.digit_count, 3);
    press(4'h3);
    submit_check("r45_resumed", 1'b1, 0);

    // Reset during entry.
    enter4(16'h6425);
    submit_check("r46_pre", 1'b1, 2);
    press(4'h0);
    press(4'h1);
    chk("r46_mid_entry", bus.digit_count, 2);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("r46_rst_entry");
    reset = 1'b0;
    enter4(16'h3210);
    submit_check("r46_ok1", 1'b1, 0);

    // Reset during lockout, via zero-digit submits.
    for (int k = 0; k < 3; k++) submit_check($sformatf("r46_z%0d", k), 1'b0, 0);
    repeat (3) @(negedge clk);
    chk("r46_in_lockout", bus.locked_out, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("r46_rst_lock");
    reset = 1'b0;
    submit_check("r46_z_after", 1'b0, 0);
    chk("r46_failcnt_cleared", bus.locked_out, 0);
    enter4(16'h3210);
    submit_check("r46_ok2", 1'b1, 0);
    chk("r46_armed", bus.armed, 1);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
